draw_processor_executor: RTL and testbench

DRAW_PROCESSOR_EXECUTOR -- requirements
Module: draw_processor_executor

---
 rtl/draw_processor_executor.sv | 225 ++++++++++++++++++++++
 tb/tb_draw_processor_executor.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_processor_executor.sv
// Draw-list executor: walks a command list in the processor RAM and rasterises
// each enabled rectangle (dashed line, wire, sprite or node dot) into a
// stream of VGA plot strobes through a two-stage pixel pipeline.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for go_draw; latches command count
// S_FETCH  | RAM address presented, two-cycle read latency
// S_DECODE | latch command word, skip disabled/empty/unknown commands
// S_DRAW   | one pixel per clock, column inner, row outer
// S_DRAIN  | two cycles for the last pixel to leave the pipeline
// S_NEXT   | advance index, finish or fetch the next command
// S_DONE   | draw_done high until go_draw drops
module draw_processor_executor (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_draw,
  output logic        draw_done,
  input  logic [9:0]  numCommands,
  output logic [9:0]  processor_addr,
  input  logic [47:0] processor_out,
  output logic [1:0]  sprite_sel,
  output logic [11:0] sprite_addr,
  input  logic [2:0]  sprite_out,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DRAW, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t      state_q;
  logic [9:0]  count_q, index_q, addr_q;
  logic        wait_q, done_q;
  logic [2:0]  type_q;
  logic [8:0]  h_q, t_q, row_q;
  logic [9:0]  w_q, l_q, col_q;
  logic [11:0] saddr_q;
  logic [1:0]  ssel_q;

  // pipeline stage 1 and stage 2 registers
  logic        s1_valid_q, s1_ok_q, s1_sprite_q;
  logic [2:0]  s1_colour_q;
  logic [9:0]  s1_x_q;
  logic [8:0]  s1_y_q;
  logic        s2_valid_q, s2_ok_q, s2_sprite_q;
  logic [2:0]  s2_colour_q;
  logic [9:0]  s2_x_q;
  logic [8:0]  s2_y_q;

  // command word fields straight off the RAM bus
  logic        cmd_en;
  logic [8:0]  cmd_type, cmd_h, cmd_t;
  logic [9:0]  cmd_w, cmd_l;
  logic        cmd_valid, cmd_sprite;

  // current pixel, evaluated in the DRAW cycle that generates it
  logic [9:0]  pix_x_d;
  logic [8:0]  pix_y_d;
  logic        pix_ok_d, pix_sprite_d;
  logic [2:0]  pix_colour_d;
  logic        last_col, last_row;

  // decode the incoming word and the current pixel position
  always_comb begin
    cmd_en     = processor_out[47];
    cmd_type   = processor_out[46:38];
    cmd_h      = processor_out[37:29];
    cmd_w      = processor_out[28:19];
    cmd_t      = processor_out[18:10];
    cmd_l      = processor_out[9:0];
    cmd_valid  = cmd_en && (cmd_w != 10'd0) && (cmd_h != 9'd0) && (cmd_type <= 9'd5);
    cmd_sprite = (cmd_type >= 9'd2) && (cmd_type <= 9'd4);

    pix_x_d      = l_q + col_q;
    pix_y_d      = t_q + row_q;
    pix_sprite_d = (type_q >= 3'd2) && (type_q <= 3'd4);
    pix_colour_d = (type_q == 3'd5) ? 3'b100 : 3'b111;
    // dashed line: 4 pixels on, 4 off along the column
    pix_ok_d     = (pix_x_d < 10'd640) && (pix_y_d < 9'd480) &&
                   !((type_q == 3'd0) && col_q[2]);
    last_col     = (col_q == w_q - 10'd1);
    last_row     = (row_q == h_q - 9'd1);
  end

  // sequencer: command fetch, decode and raster stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      type_q  <= '0;
      h_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      l_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      saddr_q <= '0;
      ssel_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_draw) begin
            count_q <= numCommands;
            index_q <= '0;
            addr_q  <= '0;
            wait_q  <= 1'b0;
            if (numCommands == 10'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          wait_q <= ~wait_q;
          if (wait_q) state_q <= S_DECODE;
        end
        S_DECODE: begin
          type_q <= cmd_type[2:0];
          h_q    <= cmd_h;
          w_q    <= cmd_w;
          t_q    <= cmd_t;
          l_q    <= cmd_l;
          if (!cmd_valid) begin
            state_q <= S_NEXT;
          end else begin
            row_q   <= '0;
            col_q   <= '0;
            saddr_q <= '0;
            ssel_q  <= cmd_sprite ? (cmd_type[1:0] - 2'd2) : 2'd0;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          // sprite_addr tracks row*W+col, which is just the pixel ordinal
          if (!(last_col && last_row)) saddr_q <= saddr_q + 12'd1;
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              wait_q  <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              row_q <= row_q + 9'd1;
            end
          end else begin
            col_q <= col_q + 10'd1;
          end
        end
        S_DRAIN: begin
          wait_q <= ~wait_q;
          if (wait_q) state_q <= S_NEXT;
        end
        S_NEXT: begin
          index_q <= index_q + 10'd1;
          addr_q  <= index_q + 10'd1;
          wait_q  <= 1'b0;
          if (index_q + 10'd1 == count_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!go_draw) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // two-stage pixel pipeline, stage 2 lines up with sprite ROM data
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_sprite_q <= 1'b0;
      s1_colour_q <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_ok_q     <= 1'b0;
      s2_sprite_q <= 1'b0;
      s2_colour_q <= '0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
    end else begin
      s1_valid_q  <= (state_q == S_DRAW);
      s1_ok_q     <= pix_ok_d;
      s1_sprite_q <= pix_sprite_d;
      s1_colour_q <= pix_colour_d;
      s1_x_q      <= pix_x_d;
      s1_y_q      <= pix_y_d;
      s2_valid_q  <= s1_valid_q;
      s2_ok_q     <= s1_ok_q;
      s2_sprite_q <= s1_sprite_q;
      s2_colour_q <= s1_colour_q;
      s2_x_q      <= s1_x_q;
      s2_y_q      <= s1_y_q;
    end
  end

  assign draw_done      = done_q;
  assign processor_addr = addr_q;
  assign sprite_addr    = saddr_q;
  assign sprite_sel     = ssel_q;
  assign vga_x          = s2_x_q;
  assign vga_y          = s2_y_q;
  // sprite colour arrives from the ROM in the same cycle; black is transparent
  assign vga_colour     = s2_sprite_q ? sprite_out : s2_colour_q;
  assign vga_plot       = s2_valid_q && s2_ok_q && (!s2_sprite_q || (sprite_out != 3'b000));

endmodule

// File: tb/tb_draw_processor_executor.sv
// Bench for draw_processor_executor: RAM/ROM models with 2-cycle latency and
// an arithmetic reference model of the expected plot stream.
module tb_draw_processor_executor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go_draw = 1'b0;
  logic        draw_done;
  logic [9:0]  numCommands = '0;
  logic [9:0]  processor_addr;
  logic [47:0] processor_out;
  logic [1:0]  sprite_sel;
  logic [11:0] sprite_addr;
  logic [2:0]  sprite_out;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  draw_processor_executor dut (
    .clk(clk), .reset(reset), .go_draw(go_draw), .draw_done(draw_done),
    .numCommands(numCommands), .processor_addr(processor_addr),
    .processor_out(processor_out), .sprite_sel(sprite_sel),
    .sprite_addr(sprite_addr), .sprite_out(sprite_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  logic [47:0] mem [0:1023];
  logic [47:0] ram_p1;
  logic [2:0]  rom_p1;

  int checks = 0;
  int failures = 0;

  logic [21:0] got_q [$];
  logic [21:0] exp_q [$];
  int first_plot_cyc, done_cyc, max_saddr;
  logic [1:0] sel_at_plot;
  logic addr_moved;

  function automatic logic [2:0] rom_val(input logic [1:0] sel, input logic [11:0] addr);
    int a;
    a = int'(addr);
    if (addr[0]) return 3'd0;
    return 3'(((a >> 1) + int'(sel)) % 7 + 1);
  endfunction

  function automatic logic [47:0] mk_word(input int en, input int typ, input int h,
                                           input int w, input int t, input int l);
    return {1'(en), 9'(typ), 9'(h), 10'(w), 9'(t), 10'(l)};
  endfunction

  // RAM and sprite ROM, both with two clocks of read latency
  always @(posedge clk) begin
    ram_p1        <= mem[processor_addr];
    processor_out <= ram_p1;
    rom_p1        <= rom_val(sprite_sel, sprite_addr);
    sprite_out    <= rom_p1;
  end

  // Reference: enumerate every pixel of every valid command in drawing order
  task automatic build_expected(input int n);
    logic [47:0] wd;
    int typ, h, w, t, l, x, y, c3;
    bit on;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      wd = mem[i];
      typ = int'(wd[46:38]); h = int'(wd[37:29]); w = int'(wd[28:19]);
      t = int'(wd[18:10]);   l = int'(wd[9:0]);
      if (wd[47] && w != 0 && h != 0 && typ <= 5) begin
        for (int r = 0; r < h; r++) begin
          for (int c = 0; c < w; c++) begin
            x = (l + c) % 1024;
            y = (t + r) % 512;
            on = 1'b1;
            c3 = 7;
            if (typ == 0) on = ((c / 4) % 2 == 0);
            else if (typ == 5) c3 = 4;
            else if (typ >= 2 && typ <= 4) begin
              c3 = int'(rom_val(2'(typ - 2), 12'((r * w + c) % 4096)));
              on = (c3 != 0);
            end
            if (on && x < 640 && y < 480) exp_q.push_back({10'(x), 9'(y), 3'(c3)});
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    go_draw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Run one list to completion, capturing the plot stream
  task automatic run_list(input int n, input bit scramble);
    int cyc;
    got_q.delete();
    first_plot_cyc = -1; done_cyc = -1; max_saddr = 0;
    sel_at_plot = 2'd3; addr_moved = 1'b0;
    @(negedge clk);
    numCommands = 10'(n);
    go_draw = 1'b1;
    cyc = 0;
    while (cyc < 20000 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (scramble) numCommands = 10'($urandom);
      if (vga_plot) begin
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        got_q.push_back({vga_x, vga_y, vga_colour});
        sel_at_plot = sprite_sel;
      end
      if (int'(sprite_addr) > max_saddr) max_saddr = int'(sprite_addr);
      if (processor_addr != 10'd0) addr_moved = 1'b1;
      if (draw_done) done_cyc = cyc;
    end
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL run_timeout: draw_done not seen within %0d cycles", cyc);
    end
    go_draw = 1'b0;
    @(negedge clk);
    checks++;
    if (draw_done !== 1'b0) begin
      failures++;
      $display("FAIL done_fall: draw_done=%b one clock after go_draw=0, want 0", draw_done);
    end
    numCommands = '0;
  endtask

  task automatic compare_plots(input string name);
    int bad, first_bad, m;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d plots, want %0d", name, got_q.size(), exp_q.size());
    end
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad = 0; first_bad = -1;
    for (int i = 0; i < m; i++)
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_pixels: %0d mismatches, first #%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
               name, bad, first_bad, got_q[first_bad][21:12], got_q[first_bad][11:3],
               got_q[first_bad][2:0], exp_q[first_bad][21:12], exp_q[first_bad][11:3],
               exp_q[first_bad][2:0]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({draw_done, vga_plot, vga_x, vga_y, vga_colour} !== 24'd0) begin
      failures++;
      $display("FAIL reset_vga: done=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
               draw_done, vga_plot, vga_x, vga_y, vga_colour);
    end
    checks++;
    if ({processor_addr, sprite_addr, sprite_sel} !== 24'd0) begin
      failures++;
      $display("FAIL reset_addr: paddr=%0d saddr=%0d sel=%0d, want 0",
               processor_addr, sprite_addr, sprite_sel);
    end
  endtask

  task automatic test_wire();
    mem[0] = mk_word(1, 1, 3, 2, 10, 20);
    run_list(1, 1'b0);
    build_expected(1);
    compare_plots("wire");
    checks++;
    if (first_plot_cyc != 6) begin
      failures++;
      $display("FAIL wire_latency: first plot at cycle %0d, want 6", first_plot_cyc);
    end
    checks++;
    if (done_cyc != 13) begin
      failures++;
      $display("FAIL wire_done_time: draw_done at cycle %0d, want 13", done_cyc);
    end
  endtask

  task automatic test_dashed();
    mem[0] = mk_word(1, 0, 1, 16, 5, 0);
    run_list(1, 1'b0);
    build_expected(1);
    compare_plots("dashed");
    checks++;
    if (got_q.size() != 8) begin
      failures++;
      $display("FAIL dashed_total: got %0d plots, want 8", got_q.size());
    end
  endtask

  task automatic test_sprite();
    mem[0] = mk_word(1, 2, 93, 44, 0, 0);
    run_list(1, 1'b0);
    build_expected(1);
    compare_plots("sprite");
    checks++;
    if (got_q.size() != 2046) begin
      failures++;
      $display("FAIL sprite_total: got %0d plots, want 2046", got_q.size());
    end
    checks++;
    if (max_saddr != 4091) begin
      failures++;
      $display("FAIL sprite_addr_max: got %0d, want 4091", max_saddr);
    end
    checks++;
    if (sel_at_plot !== 2'd0) begin
      failures++;
      $display("FAIL sprite_sel: got %0d, want 0", sel_at_plot);
    end
  endtask

  task automatic test_skip();
    mem[0] = mk_word(1, 1, 2, 2, 50, 60);
    mem[1] = mk_word(0, 1, 4, 4, 0, 0);
    mem[2] = mk_word(1, 5, 3, 0, 0, 0);
    run_list(3, 1'b0);
    build_expected(3);
    compare_plots("skip");
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL skip_total: got %0d plots, want 4", got_q.size());
    end
  endtask

  task automatic test_zero_count();
    run_list(0, 1'b0);
    checks++;
    if (done_cyc < 1 || done_cyc > 2) begin
      failures++;
      $display("FAIL zero_done_time: draw_done at cycle %0d, want 1..2", done_cyc);
    end
    checks++;
    if (addr_moved || got_q.size() != 0) begin
      failures++;
      $display("FAIL zero_no_work: addr_moved=%b plots=%0d, want 0 and 0", addr_moved, got_q.size());
    end
  endtask

  task automatic test_clip_and_reset();
    int cyc;
    mem[0] = mk_word(1, 5, 1, 6, 100, 636);
    run_list(1, 1'b0);
    build_expected(1);
    compare_plots("clip");
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL clip_total: got %0d plots, want 4", got_q.size());
    end
    // abort a long command mid-draw
    mem[0] = mk_word(1, 1, 20, 20, 0, 0);
    @(negedge clk);
    numCommands = 10'd1;
    go_draw = 1'b1;
    cyc = 0;
    while (!vga_plot && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!vga_plot) begin
      failures++;
      $display("FAIL abort_setup: no plot within 100 cycles");
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({vga_plot, draw_done, processor_addr} !== 12'd0) begin
      failures++;
      $display("FAIL abort_outputs: plot=%b done=%b paddr=%0d, want 0", vga_plot, draw_done, processor_addr);
    end
    go_draw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // a fresh list must start from IDLE with the nominal latency
    mem[0] = mk_word(1, 1, 3, 2, 10, 20);
    run_list(1, 1'b0);
    build_expected(1);
    compare_plots("after_abort");
    checks++;
    if (first_plot_cyc != 6) begin
      failures++;
      $display("FAIL abort_idle: first plot at cycle %0d after reset, want 6", first_plot_cyc);
    end
  endtask

  task automatic test_random();
    int n, typ;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        typ = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 511) : $urandom_range(0, 5);
        mem[i] = mk_word(($urandom_range(0, 4) != 0) ? 1 : 0, typ,
                         $urandom_range(0, 6), $urandom_range(0, 12),
                         $urandom_range(0, 511), $urandom_range(0, 1023));
      end
      run_list(n, 1'b1);
      build_expected(n);
      compare_plots("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_wire();
    test_dashed();
    test_sprite();
    test_skip();
    test_zero_count();
    test_clip_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
